sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter.sv | 99 +++++++++
 tb/tb_sram_arbiter.sv | 130 +++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// Two-requester arbiter (fetch, data) for a shared single-port SRAM with 1-cycle read latency.
// Data has priority, and a starvation counter forces a fetch grant once it saturates.
//
// resp_own states
//   state     | meaning
//   OWN_NONE  | no read response due this cycle
//   OWN_IF    | sram_rdata this cycle belongs to the fetch port
//   OWN_DS    | sram_rdata this cycle belongs to the data port
module sram_arbiter #(
  parameter int XLEN       = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_req,
  input  logic [XLEN-1:0] i_addr,
  output logic            i_gnt,
  output logic            i_rvalid,
  output logic [XLEN-1:0] i_rdata,
  input  logic            d_req,
  input  logic [3:0]      d_wen,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [XLEN-1:0] d_rdata,
  output logic            sram_en,
  output logic [3:0]      sram_wen,
  output logic [XLEN-1:0] sram_addr,
  output logic [XLEN-1:0] sram_wdata,
  input  logic [XLEN-1:0] sram_rdata
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DS   = 2'd2
  } own_e;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  own_e       resp_own, resp_own_nxt;
  logic [3:0] starve_cnt, starve_nxt;
  logic       fetch_pri;

  assign fetch_pri = (starve_cnt == STARVE_LIM);

  // Grants are gated by reset so nothing reaches the SRAM while it is held.
  always_comb begin
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    if (reset) begin
      if (i_req && (!d_req || fetch_pri)) i_gnt = 1'b1;
      else if (d_req)                     d_gnt = 1'b1;
    end
  end

  always_comb begin
    sram_en    = i_gnt | d_gnt;
    sram_wen   = 4'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    if (i_gnt) begin
      sram_addr = i_addr;
    end else if (d_gnt) begin
      sram_wen   = d_wen;
      sram_addr  = d_addr;
      sram_wdata = d_wdata;
    end
  end

  always_comb begin
    starve_nxt = starve_cnt;
    if (i_gnt || !i_req)     starve_nxt = 4'd0;
    else if (d_gnt && !fetch_pri) starve_nxt = starve_cnt + 4'd1;
  end

  always_comb begin
    resp_own_nxt = OWN_NONE;
    if (i_gnt)                        resp_own_nxt = OWN_IF;
    else if (d_gnt && d_wen == 4'b0)  resp_own_nxt = OWN_DS;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resp_own   <= OWN_NONE;
      starve_cnt <= 4'd0;
    end else begin
      resp_own   <= resp_own_nxt;
      starve_cnt <= starve_nxt;
    end
  end

  assign i_rvalid = (resp_own == OWN_IF);
  assign d_rvalid = (resp_own == OWN_DS);
  assign i_rdata  = i_rvalid ? sram_rdata : '0;
  assign d_rdata  = d_rvalid ? sram_rdata : '0;

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed scenarios then randomized traffic,
// compared each cycle against a cycle-level reference model of the arbitration rules.
module tb_sram_arbiter;
  localparam int XLEN = 32;
  localparam int SMAX = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            i_req, d_req;
  logic [XLEN-1:0] i_addr, d_addr, d_wdata, sram_rdata;
  logic [3:0]      d_wen;
  logic            i_gnt, d_gnt, i_rvalid, d_rvalid, sram_en;
  logic [XLEN-1:0] i_rdata, d_rdata, sram_addr, sram_wdata;
  logic [3:0]      sram_wen;

  int n_cmp  = 0;
  int n_fail = 0;

  // reference model state: pending response owner (0 none, 1 fetch, 2 data) and starvation count
  int m_pend   = 0;
  int m_starve = 0;

  sram_arbiter #(.XLEN(XLEN), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .sram_en(sram_en), .sram_wen(sram_wen), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs, check every output against the model, then advance the model.
  task automatic step(input logic rst, input logic ir, input logic [XLEN-1:0] ia,
                      input logic dr, input logic [3:0] dw, input logic [XLEN-1:0] da,
                      input logic [XLEN-1:0] dd);
    logic eg_i, eg_d;
    @(negedge clk);
    reset = rst; i_req = ir; i_addr = ia; d_req = dr; d_wen = dw; d_addr = da; d_wdata = dd;
    sram_rdata = $urandom;
    #1;
    if (!rst) begin
      m_pend = 0;
      m_starve = 0;
    end
    eg_i = rst && ir && (!dr || m_starve == SMAX);
    eg_d = rst && dr && !eg_i;
    chk("i_gnt", i_gnt, eg_i);
    chk("d_gnt", d_gnt, eg_d);
    chk("sram_en", sram_en, eg_i || eg_d);
    chk("sram_addr", sram_addr, eg_i ? ia : (eg_d ? da : 0));
    chk("sram_wen", sram_wen, eg_d ? dw : 4'b0);
    chk("sram_wdata", sram_wdata, eg_d ? dd : 0);
    chk("i_rvalid", i_rvalid, m_pend == 1);
    chk("d_rvalid", d_rvalid, m_pend == 2);
    chk("i_rdata", i_rdata, (m_pend == 1) ? sram_rdata : 0);
    chk("d_rdata", d_rdata, (m_pend == 2) ? sram_rdata : 0);
    if (rst) begin
      if (eg_i || !ir)      m_starve = 0;
      else if (eg_d)        m_starve = (m_starve + 1 > SMAX) ? SMAX : m_starve + 1;
      m_pend = eg_i ? 1 : ((eg_d && dw == 4'b0) ? 2 : 0);
    end
  endtask

  task automatic idle(input logic rst);
    step(rst, 1'b0, '0, 1'b0, 4'b0, '0, '0);
  endtask

  initial begin
    logic [3:0] w;
    reset = 1'b0; i_req = 1'b0; d_req = 1'b0; d_wen = '0;
    i_addr = '0; d_addr = '0; d_wdata = '0; sram_rdata = '0;

    // reset holds grants low even with requests present
    step(1'b0, 1'b1, 32'h40, 1'b1, 4'b0, 32'h80, 32'h1);
    step(1'b0, 1'b1, 32'h44, 1'b0, 4'b0, 32'h0, 32'h0);
    idle(1'b1);

    // fetch alone, response next cycle
    step(1'b1, 1'b1, 32'h100, 1'b0, 4'b0, '0, '0);
    idle(1'b1);

    // continuous contention: starvation forces a fetch every fifth cycle
    for (int c = 0; c < 12; c++)
      step(1'b1, 1'b1, 32'h1000 + 32'(c * 4), 1'b1, 4'b0, 32'h2000 + 32'(c * 4), 32'h0);
    idle(1'b1);

    // data write: no read response afterwards
    step(1'b1, 1'b0, '0, 1'b1, 4'b0011, 32'h200, 32'hA5A5);
    idle(1'b1);
    idle(1'b1);

    // back-to-back fetches
    step(1'b1, 1'b1, 32'h0, 1'b0, 4'b0, '0, '0);
    step(1'b1, 1'b1, 32'h4, 1'b0, 4'b0, '0, '0);
    step(1'b1, 1'b1, 32'h8, 1'b0, 4'b0, '0, '0);
    idle(1'b1);
    idle(1'b1);

    // reset during a pending data read discards the response
    step(1'b1, 1'b0, '0, 1'b1, 4'b0, 32'h300, '0);
    idle(1'b0);
    idle(1'b1);
    idle(1'b1);

    // starvation count builds, then fetch drops: count must restart from zero
    for (int c = 0; c < 3; c++) step(1'b1, 1'b1, 32'h10, 1'b1, 4'b0, 32'h20, '0);
    step(1'b1, 1'b0, '0, 1'b1, 4'b0, 32'h24, '0);
    for (int c = 0; c < 6; c++) step(1'b1, 1'b1, 32'h14, 1'b1, 4'b1111, 32'h28, 32'hDEAD);

    // randomized traffic with occasional reset pulses
    for (int c = 0; c < 3000; c++) begin
      w = ($urandom_range(0, 1) == 0) ? 4'b0 : 4'($urandom);
      step(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) != 0), $urandom,
           ($urandom_range(0, 3) != 0), w, $urandom, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
